q_proj_mac: RTL
===============

# q_proj_mac

Downstream consumer of the Q-projection window counter. Its `win_i` input connects to the counter's `out` output, and the counter holds `win_i` high for exactly LEN cycles per write. While `win_i` is high, the block multiply-accumulates one signed activation/weight pair per cycle onto a bias. When the window closes, it rounds by shift, saturates, and holds the result behind a valid/ready handshake for the next Q-projection stage.

## Interface
- DATA_W, 8: signed width of act_i, wt_i and res_o
- ACC_W, 20: signed accumulator width; must be at least 2*DATA_W + clog2(LEN) + 1
- LEN, 7: expected samples per window; equals the counter's `count`
- SHIFT, 4: arithmetic right shift applied to the accumulator before saturation
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- win_i  in  1  sample window from the counter; one pair is consumed per cycle while high
- act_i  in  DATA_W  signed activation, sampled when win_i=1
- wt_i  in  DATA_W  signed weight, sampled when win_i=1
- bias_i  in  2*DATA_W  signed bias, sampled on the first cycle of a window
- res_o  out  DATA_W  saturated result
- res_valid_o  out  1  result available
- res_ready_i  in  1  downstream accepts the result
- len_err_o  out  1  result was built from a sample count other than LEN; valid with res_valid_o
- busy_o  out  1  high in ACCUM and DONE; upstream must not issue write_en while high
- ovr_o  out  1  sticky: a window arrived while a result was still unaccepted; cleared only by rst

## Operation
- States: IDLE, ACCUM, DONE.
- Reset: state=IDLE; acc, cnt, res_o = 0; res_valid_o, len_err_o, busy_o, ovr_o = 0.
- IDLE, win_i=1: acc ← sext(bias_i) + act_i*wt_i; cnt ← 1; go to ACCUM.
- IDLE, win_i=0: hold state.
- ACCUM, win_i=1, cnt<LEN: acc ← acc + act_i*wt_i; cnt ← cnt+1.
- ACCUM, win_i=1, cnt=LEN: sample dropped; extra flag set.
- ACCUM, win_i=0:
  - res_o ← sat(acc >>> SHIFT).
  - len_err_o ← (cnt≠LEN) | extra.
  - res_valid_o ← 1; go to DONE.
- DONE, res_valid_o & res_ready_i: res_valid_o ← 0.
  - If win_i=1 in the same cycle: start a new window exactly as in IDLE and go to ACCUM.
  - Otherwise go to IDLE.
- DONE, not accepted, win_i=1: samples ignored; ovr_o ← 1; res_o and state held.
- Arithmetic:
  - Products are full 2*DATA_W signed, sign-extended to ACC_W.
  - The shift is arithmetic, i.e. floor.
  - sat clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - With the ACC_W rule above, the accumulator cannot wrap.
- busy_o = (state≠IDLE), registered with the state.

## Timing
- First sample is taken at the edge where win_i is first seen high. There is no setup cycle.
- res_valid_o rises 1 cycle after the last window cycle (the edge that sees win_i=0).
- Counter write_en at edge E → samples at edges E+1..E+LEN → res_valid_o high after edge E+LEN+1.
- Minimum result period is LEN+1 cycles when res_ready_i is tied high.
- res_o and len_err_o remain stable while res_valid_o=1 and res_ready_i=0.
- rst asserted mid-window or mid-DONE: immediate return to reset values; any pending result is lost.

## Structure
- Package q_proj_pkg holds:
  - the state enum (IDLE, ACCUM, DONE)
  - default widths: DATA_W=8, ACC_W=20, LEN=7, SHIFT=4
  - a function returning the minimum ACC_W for a given DATA_W/LEN
- Sub-module q_proj_sat: combinational shift-and-saturate, ACC_W in, DATA_W out. Reused by later projection stages.
- q_proj_mac holds the FSM, accumulator, counter and output registers.

## Test plan
- 7-cycle window, act=10, wt=3, bias=0, ready=1 → res_o=13 (210>>>4), len_err=0, valid for 1 cycle.
- 7 cycles of act=127, wt=127 → acc=112903 → res_o=127 (positive saturation). Same with act=-128 → res_o=-128.
- 7 cycles of act=-5, wt=3, bias=0 → acc=-105 → res_o=-7 (floor). Repeat with bias=200 → acc=95 → res_o=5.
- 5-cycle window → len_err_o=1. 9-cycle window of act=1, wt=16 → acc=112, res_o=7, len_err_o=1.
- Backpressure:
  - ready=0 for 10 cycles: res_o held.
  - Second window during the hold → ovr_o=1, result unchanged.
  - ready rises together with a new window → that window's result is correct.
- rst pulse at sample 4 of a window → all outputs 0 next cycle. A following clean window → correct result.

Source files
------------

// File: rtl/q_proj_pkg.sv
// Shared types and default widths for the Q-projection datapath stages.
// Consumers use import q_proj_pkg::*.
package q_proj_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 20;
    localparam int DEF_LEN    = 7;
    localparam int DEF_SHIFT  = 4;

    // Full-width products, LEN of them, plus the bias term.
    function automatic int min_acc_w(input int data_w, input int len);
        return 2 * data_w + $clog2(len) + 1;
    endfunction

endpackage

// File: rtl/q_proj_sat.sv
// Arithmetic right shift (floor) followed by clamp to the signed DATA_W range.
// Pure combinational; shared with later projection stages.
module q_proj_sat
    import q_proj_pkg::*;
#(
    parameter int ACC_W  = DEF_ACC_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SHIFT  = DEF_SHIFT
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    output logic signed [DATA_W-1:0] res_o
);

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] max_v;
        logic signed [ACC_W-1:0] min_v;
        max_v = '0;
        max_v[DATA_W-2:0] = '1;
        min_v = '1;
        min_v[DATA_W-2:0] = '0;
        if (v > max_v) begin
            return max_v[DATA_W-1:0];
        end else if (v < min_v) begin
            return min_v[DATA_W-1:0];
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

    logic signed [ACC_W-1:0] shifted;

    assign shifted = acc_i >>> SHIFT;
    assign res_o   = sat(shifted);

endmodule

// File: rtl/q_proj_mac.sv
// Windowed multiply-accumulate onto a bias; rounds, saturates and holds the
// result behind a valid/ready handshake until the next stage accepts it.
module q_proj_mac
    import q_proj_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN    = DEF_LEN,
    parameter int SHIFT  = DEF_SHIFT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       win_i,
    input  logic signed [DATA_W-1:0]   act_i,
    input  logic signed [DATA_W-1:0]   wt_i,
    input  logic signed [2*DATA_W-1:0] bias_i,
    output logic signed [DATA_W-1:0]   res_o,
    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    output logic                       len_err_o,
    output logic                       busy_o,
    output logic                       ovr_o
);

    localparam int CNT_W = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

    if (ACC_W < min_acc_w(DATA_W, LEN)) begin : g_acc_w_check
        $error("q_proj_mac: ACC_W too small for DATA_W/LEN");
    end

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     extra_q, extra_d;
    logic signed [DATA_W-1:0] res_q, res_d;
    logic                     vld_q, vld_d;
    logic                     lerr_q, lerr_d;
    logic                     ovr_q, ovr_d;
    logic                     busy_q;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [DATA_W-1:0]   sat_res;

    assign prod     = act_i * wt_i;
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-2*DATA_W){bias_i[2*DATA_W-1]}}, bias_i};

    q_proj_sat #(
        .ACC_W (ACC_W),
        .DATA_W(DATA_W),
        .SHIFT (SHIFT)
    ) u_sat (
        .acc_i(acc_q),
        .res_o(sat_res)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        extra_d = extra_q;
        res_d   = res_q;
        vld_d   = vld_q;
        lerr_d  = lerr_q;
        ovr_d   = ovr_q;
        unique case (state_q)
            IDLE: begin
                if (win_i) begin
                    acc_d   = bias_ext + prod_ext;
                    cnt_d   = CNT_W'(1);
                    extra_d = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (win_i) begin
                    if (cnt_q < LEN_C) begin
                        acc_d = acc_q + prod_ext;
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        extra_d = 1'b1;
                    end
                end else begin
                    res_d   = sat_res;
                    lerr_d  = (cnt_q != LEN_C) | extra_q;
                    vld_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (vld_q && res_ready_i) begin
                    vld_d = 1'b0;
                    // Back-to-back window: its first sample is this cycle's pair.
                    if (win_i) begin
                        acc_d   = bias_ext + prod_ext;
                        cnt_d   = CNT_W'(1);
                        extra_d = 1'b0;
                        state_d = ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (win_i) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            extra_q <= 1'b0;
            res_q   <= '0;
            vld_q   <= 1'b0;
            lerr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            extra_q <= extra_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
            lerr_q  <= lerr_d;
            ovr_q   <= ovr_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign res_o       = res_q;
    assign res_valid_o = vld_q;
    assign len_err_o   = lerr_q;
    assign busy_o      = busy_q;
    assign ovr_o       = ovr_q;

endmodule
